// File: rtl/vga_fb_rd_dma.sv
// AXI4 read master that streams one framebuffer frame into an on-chip pixel FIFO.
// Bursts are fixed-length INCR, one outstanding, issued only when the FIFO can absorb them.
module vga_fb_rd_dma #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [31:0]           frame_bytes_i,
  input  logic                  frame_start_i,
  output logic [ID_WIDTH-1:0]   arid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [ID_WIDTH-1:0]   rid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic                  pix_valid_o,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  input  logic                  pix_ready_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  underrun_o
);

  localparam int unsigned BurstBytes = BURST_LEN * DATA_WIDTH / 8;
  localparam int unsigned SizeLog    = $clog2(DATA_WIDTH / 8);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned BeatW      = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]           remain_q, remain_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic                  discard_q, discard_d;
  logic                  flush_q, flush_d;
  logic                  err_q, err_d;
  logic                  underrun_q, underrun_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic start, busy, r_hs, r_end, push, pop, free_ok;
  logic unused_rid;

  assign unused_rid = ^rid_i;
  assign start      = frame_start_i && en_i;
  assign busy       = (remain_q != 32'd0) || (state_q != StIdle);
  assign r_hs       = (state_q == StR) && rvalid_i;
  assign r_end      = r_hs && (rlast_i || (beat_q == BeatW'(BURST_LEN - 1)));
  assign push       = r_hs && !discard_q;
  assign pop        = pix_valid_o && pix_ready_i;
  assign free_ok    = (32'(FIFO_DEPTH) - 32'(cnt_q)) >= 32'(BURST_LEN);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    araddr_d   = araddr_q;
    beat_d     = beat_q;
    discard_d  = discard_q;
    err_d      = err_q;
    underrun_d = underrun_q;
    flush_d    = start && busy;
    case (state_q)
      StIdle: begin
        // A start in this cycle re-targets addr; don't launch a burst from the stale one.
        if (en_i && !start && (remain_q != 32'd0) && free_ok) begin
          state_d  = StAr;
          araddr_d = addr_q;
        end
      end
      StAr: begin
        if (arready_i) begin
          state_d = StR;
          beat_d  = '0;
          // A burst marked for discard belongs to an abandoned frame.
          if (!discard_q) begin
            addr_d   = addr_q + ADDR_WIDTH'(BurstBytes);
            remain_d = remain_q - 32'd1;
          end
        end
      end
      StR: begin
        if (rvalid_i) begin
          beat_d = beat_q + BeatW'(1);
          if (r_end) begin
            state_d   = StIdle;
            discard_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      addr_d   = base_addr_i;
      remain_d = frame_bytes_i / 32'(BurstBytes);
      if (state_d != StIdle) discard_d = 1'b1;
    end
    if (r_hs && (rresp_i != 2'b00)) err_d = 1'b1;
    if (pix_ready_i && busy && (cnt_q == '0)) underrun_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      araddr_q   <= '0;
      remain_q   <= '0;
      beat_q     <= '0;
      discard_q  <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      araddr_q   <= araddr_d;
      remain_q   <= remain_d;
      beat_q     <= beat_d;
      discard_q  <= discard_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= rdata_i;
  end

  assign arid_o      = ID_WIDTH'(AXI_ID);
  assign arlen_o     = 8'(BURST_LEN - 1);
  assign arsize_o    = 3'(SizeLog);
  assign arburst_o   = 2'b01;
  assign araddr_o    = araddr_q;
  assign arvalid_o   = (state_q == StAr);
  assign rready_o    = (state_q == StR);
  assign pix_valid_o = (cnt_q != '0);
  assign pix_data_o  = pix_valid_o ? mem_q[rd_ptr_q] : '0;
  assign busy_o      = busy;
  assign err_o       = err_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_vga_fb_rd_dma.sv
// Bench for vga_fb_rd_dma: AXI read-slave model plus a pixel-word scoreboard.
module tb_vga_fb_rd_dma;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int BL = 16;
  localparam int BB = BL * DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          en_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [31:0]   frame_bytes_i = '0;
  logic          frame_start_i = 1'b0;
  logic [IW-1:0] arid_o;
  logic [AW-1:0] araddr_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic          arvalid_o;
  logic          arready_i = 1'b1;
  logic [IW-1:0] rid_i = '0;
  logic [DW-1:0] rdata_i = '0;
  logic [1:0]    rresp_i = 2'b00;
  logic          rlast_i = 1'b0;
  logic          rvalid_i = 1'b0;
  logic          rready_o;
  logic          pix_valid_o;
  logic [DW-1:0] pix_data_o;
  logic          pix_ready_i = 1'b0;
  logic          busy_o;
  logic          err_o;
  logic          underrun_o;

  always #5 aclk = ~aclk;

  vga_fb_rd_dma dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .en_i          (en_i),
    .base_addr_i   (base_addr_i),
    .frame_bytes_i (frame_bytes_i),
    .frame_start_i (frame_start_i),
    .arid_o        (arid_o),
    .araddr_o      (araddr_o),
    .arlen_o       (arlen_o),
    .arsize_o      (arsize_o),
    .arburst_o     (arburst_o),
    .arvalid_o     (arvalid_o),
    .arready_i     (arready_i),
    .rid_i         (rid_i),
    .rdata_i       (rdata_i),
    .rresp_i       (rresp_i),
    .rlast_i       (rlast_i),
    .rvalid_i      (rvalid_i),
    .rready_o      (rready_o),
    .pix_valid_o   (pix_valid_o),
    .pix_data_o    (pix_data_o),
    .pix_ready_i   (pix_ready_i),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .underrun_o    (underrun_o)
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] ar_log[$];
  int ar_bad = 0;

  // Slave model state
  logic [AW-1:0] s_addr = '0;
  int s_beat = 0;
  bit s_act = 0;
  int stall_left = 0;
  int burst_no = 0;
  int err_burst = -1;
  int err_beat = -1;
  bit err_seen = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'h5a5a_a5a5, a};
  endfunction

  always begin
    @(posedge aclk);
    if (!aresetn) begin
      s_act = 0;
      s_beat = 0;
    end else begin
      if (arvalid_o && arready_i) begin
        ar_log.push_back(araddr_o);
        if (arlen_o != 8'd15 || arsize_o != 3'd3 || arburst_o != 2'b01 || arid_o != '0)
          ar_bad++;
        s_addr = araddr_o;
        s_beat = 0;
        s_act = 1;
        burst_no++;
      end else if (arvalid_o && stall_left > 0) begin
        stall_left--;
      end
      if (rvalid_i && rready_o) begin
        if (rresp_i != 2'b00) err_seen = 1;
        s_beat++;
        if (s_beat == BL) s_act = 0;
      end
    end
    #1;
    arready_i = (stall_left == 0);
    rvalid_i  = s_act;
    rlast_i   = s_act && (s_beat == BL - 1);
    rdata_i   = s_act ? mem_word(s_addr + AW'(s_beat * 8)) : '0;
    rresp_i   = (s_act && burst_no == err_burst && s_beat == err_beat) ? 2'b10 : 2'b00;
  end

  // Scoreboard: every popped word must be the next expected framebuffer word.
  always @(negedge aclk) begin
    if (aresetn && pix_valid_o && pix_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pix_pop: got %h, required no word (queue empty)", pix_data_o);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (pix_data_o !== e) begin
          bad++;
          $display("FAIL pix_data: got %h, required %h", pix_data_o, e);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input logic [31:0] bytes,
                             input bit push_exp);
    base_addr_i = base;
    frame_bytes_i = bytes;
    frame_start_i = 1'b1;
    cycles(1);
    frame_start_i = 1'b0;
    if (push_exp)
      for (int i = 0; i < int'(bytes / BB) * BL; i++)
        exp_q.push_back(mem_word(base + AW'(i * 8)));
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      cycles(1);
    end
  endtask

  task automatic test_reset();
    bit found;
    int n0;
    cycles(3);
    total++;
    if ({arvalid_o, rready_o, busy_o, pix_valid_o, err_o, underrun_o} !== 6'b0 ||
        araddr_o !== '0) begin
      bad++;
      $display("FAIL reset_state: got flags %b addr %h, required 0", {arvalid_o, rready_o,
               busy_o, pix_valid_o, err_o, underrun_o}, araddr_o);
    end
    aresetn = 1'b1;
    en_i = 1'b1;
    cycles(2);
    start_frame(32'h1000_0000, 32'd256, 1'b0);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (rready_o && rvalid_i) begin
        found = 1;
        break;
      end
      cycles(1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_wait_r: got no R beat, required one within 50 cycles");
    end
    cycles(3);
    #3 aresetn = 1'b0;
    #1;
    total++;
    if ({arvalid_o, rready_o, busy_o, pix_valid_o, err_o, underrun_o} !== 6'b0 ||
        araddr_o !== '0 || pix_data_o !== '0) begin
      bad++;
      $display("FAIL reset_mid_burst: got flags %b addr %h, required 0", {arvalid_o, rready_o,
               busy_o, pix_valid_o, err_o, underrun_o}, araddr_o);
    end
    cycles(2);
    aresetn = 1'b1;
    n0 = ar_log.size();
    cycles(20);
    total++;
    if (ar_log.size() != n0 || arvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_ar: got %0d ARs, required 0", ar_log.size() - n0);
    end
  endtask

  task automatic test_basic_frame();
    int n0;
    bit ok;
    pix_ready_i = 1'b1;
    n0 = ar_log.size();
    start_frame(32'h8000_0000, 32'd256, 1'b1);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: got %b, required 1", busy_o);
    end
    wait_done(2000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_done: got busy %b left %0d, required idle and drained",
               busy_o, exp_q.size());
    end
    total++;
    if (ar_log.size() - n0 != 2) begin
      bad++;
      $display("FAIL basic_ar_count: got %0d, required 2", ar_log.size() - n0);
    end else begin
      total++;
      if (ar_log[n0] !== 32'h8000_0000 || ar_log[n0+1] !== 32'h8000_0080) begin
        bad++;
        $display("FAIL basic_araddr: got %h %h, required 80000000 80000080",
                 ar_log[n0], ar_log[n0+1]);
      end
    end
    total++;
    if (ar_bad != 0) begin
      bad++;
      $display("FAIL ar_fields: got %0d bad ARs, required 0", ar_bad);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    bit ok;
    pix_ready_i = 1'b0;
    n0 = ar_log.size();
    start_frame(32'h4000_0000, 32'd1024, 1'b1);
    cycles(200);
    total++;
    if (ar_log.size() - n0 != 4 || arvalid_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_stall: got %0d ARs arvalid %b busy %b, required 4 0 1",
               ar_log.size() - n0, arvalid_o, busy_o);
    end
    pix_ready_i = 1'b1;
    cycles(16);
    pix_ready_i = 1'b0;
    cycles(30);
    total++;
    if (ar_log.size() - n0 != 5) begin
      bad++;
      $display("FAIL bp_fifth_ar: got %0d ARs, required 5", ar_log.size() - n0);
    end else begin
      total++;
      if (ar_log[n0+4] !== 32'h4000_0200) begin
        bad++;
        $display("FAIL bp_fifth_addr: got %h, required 40000200", ar_log[n0+4]);
      end
    end
    pix_ready_i = 1'b1;
    wait_done(3000, ok);
    total++;
    if (!ok || ar_log.size() - n0 != 8) begin
      bad++;
      $display("FAIL bp_done: got ok %b ARs %0d, required 1 8", ok, ar_log.size() - n0);
    end
  endtask

  task automatic test_ar_stall();
    int n0;
    bit found, ok;
    logic [AW-1:0] a;
    logic [7:0] l;
    pix_ready_i = 1'b1;
    stall_left = 10;
    n0 = ar_log.size();
    start_frame(32'h2000_0000, 32'd128, 1'b1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (arvalid_o) begin
        found = 1;
        break;
      end
      cycles(1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stall_arvalid: got none, required arvalid within 20 cycles");
    end
    a = araddr_o;
    l = arlen_o;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (arvalid_o !== 1'b1 || araddr_o !== a || arlen_o !== l || ar_log.size() != n0) begin
        bad++;
        $display("FAIL stall_hold%0d: got v %b addr %h len %0d hs %0d, required 1 %h %0d 0",
                 i, arvalid_o, araddr_o, arlen_o, ar_log.size() - n0, a, l);
      end
      cycles(1);
    end
    wait_done(500, ok);
    total++;
    if (!ok || ar_log.size() - n0 != 1 || a !== 32'h2000_0000) begin
      bad++;
      $display("FAIL stall_release: got ok %b ARs %0d addr %h, required 1 1 20000000",
               ok, ar_log.size() - n0, a);
    end
  endtask

  task automatic test_err();
    bit ok, found, prev;
    pix_ready_i = 1'b1;
    err_burst = burst_no + 1;
    err_beat = 4;
    err_seen = 0;
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_initial: got %b, required 0", err_o);
    end
    start_frame(32'h3000_0000, 32'd256, 1'b1);
    found = 0;
    prev = err_o;
    for (int i = 0; i < 100; i++) begin
      if (err_seen) begin
        found = 1;
        break;
      end
      prev = err_o;
      cycles(1);
    end
    total++;
    if (!found || prev !== 1'b0 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_rise: got seen %b before %b after %b, required 1 0 1",
               found, prev, err_o);
    end
    wait_done(1000, ok);
    err_burst = -1;
    total++;
    if (!ok || err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got ok %b err %b, required 1 1", ok, err_o);
    end
  endtask

  task automatic test_resync();
    int bn0, n1;
    bit found, ok, leak;
    pix_ready_i = 1'b0;
    aresetn = 1'b0;
    cycles(2);
    aresetn = 1'b1;
    exp_q.delete();
    cycles(1);
    bn0 = burst_no;
    start_frame(32'h5000_0000, 32'd512, 1'b0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (burst_no == bn0 + 2 && s_beat == 8) begin
        found = 1;
        break;
      end
      cycles(1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL resync_reach: got burst %0d beat %0d, required burst 2 beat 8",
               burst_no - bn0, s_beat);
    end
    n1 = ar_log.size();
    start_frame(32'h9000_0000, 32'd256, 1'b1);
    cycles(1);
    total++;
    if (pix_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL resync_flush: got valid %b busy %b, required 0 1", pix_valid_o, busy_o);
    end
    found = 0;
    leak = 0;
    for (int i = 0; i < 100; i++) begin
      if (pix_valid_o) leak = 1;
      if (ar_log.size() > n1) begin
        found = 1;
        break;
      end
      cycles(1);
    end
    total++;
    if (!found || leak) begin
      bad++;
      $display("FAIL resync_discard: got new AR %b fifo filled %b, required 1 0", found, leak);
    end else begin
      total++;
      if (ar_log.size() - n1 != 1 || ar_log[n1] !== 32'h9000_0000) begin
        bad++;
        $display("FAIL resync_addr: got %h (%0d ARs), required 90000000 (1 AR)",
                 ar_log[n1], ar_log.size() - n1);
      end
    end
    total++;
    if (underrun_o !== 1'b0) begin
      bad++;
      $display("FAIL resync_no_underrun: got %b, required 0", underrun_o);
    end
    pix_ready_i = 1'b1;
    wait_done(1000, ok);
    total++;
    if (!ok || underrun_o !== 1'b1) begin
      bad++;
      $display("FAIL resync_underrun: got ok %b underrun %b, required 1 1", ok, underrun_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_ar_stall();
    test_err();
    test_resync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
